exec_bus_sequencer: RTL and testbench
=====================================

Name: exec_bus_sequencer

Overview:
- Executes the per-cycle machine states issued by the CPU control unit.
- Turns each state code into PC/IR updates, memory bus transactions (req/ack with timeout), register-write and ALU-start strobes.
- Raises halt_req back to the control unit.
- Sits between the control unit and the memory/register-file/ALU datapath; it is the consumer end of the state/opcode/addressing-mode interface.

Parameters:
- ADDR_W, 8, memory address and PC width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack (1..255).
- OP_STR, 5'h07, opcode selecting a bus write in S_MEM_W.
- OP_JMP / OP_JZ / OP_JNZ / OP_JC / OP_JNC, 5'h0C / 5'h0D / 5'h0E / 5'h0F / 5'h10, jump opcodes.

Ports:
- clk  in  1  clock, rising edge.
- reset_cycle  in  1  asynchronous, active-high reset.
- state  in  4  state code: 0 FETCH_PC, 1 FETCH_INST, 2 MEM_R, 3 MEM_W, 4 ALU_FETCH, 5 ALU_OUT, 6 JMP, 7 NEXT, 8 HALT.
- state_valid  in  1  one-cycle strobe presenting a new state.
- opcode  in  5  current opcode.
- addrm  in  3  addressing mode: 1 immediate, 2 register, 3 direct.
- z_flag, c_flag  in  1 each  ALU flags.
- reg_rdata  in  16  source register value.
- alu_result  in  16  ALU output.
- mem_rdata  in  16  memory read data.
- mem_ack  in  1  memory completion strobe.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  16  write data.
- pc  out  ADDR_W  program counter.
- ir  out  16  instruction register.
- reg_we  out  1  register-file write strobe.
- reg_wdata  out  16  register-file write data.
- alu_go  out  1  ALU start strobe.
- jmp_taken  out  1  one-cycle pulse when a jump loads the PC.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- halt_req  out  1  sticky halt request.
- bus_err  out  1  sticky timeout flag.
- seq_err  out  1  sticky flag: overrun or illegal state.
- instr_count  out  16  retired instruction count.

Behaviour:
- Reset (async, reset_cycle=1): pc=RESET_PC, ir=0, internal data_reg=0, timeout counter=0, FSM=IDLE; every other output 0.
  - Reset during a bus transaction drops mem_req immediately and abandons it; a later mem_ack is ignored.
- FSM states: IDLE, EXEC, BUS, DONE.
  - IDLE: state_valid with halt_req=0 is accepted. Bus-type states go to BUS with mem_req=1; all others go to EXEC.
  - EXEC: performs its single-cycle action, goes to DONE.
  - BUS: holds mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack; the action completes on the ack edge, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - busy=1 in EXEC, BUS and DONE.
- Latency: non-bus states give done 2 cycles after the accept edge; bus states give done 1 cycle after the mem_ack sample.
- Per-state actions:
  - FETCH_PC: mem_addr<=pc (no bus).
  - FETCH_INST: bus read at pc. On ack, ir<=mem_rdata and pc<=pc+1, wrapping modulo 2^ADDR_W.
  - MEM_R: addrm=1 → data_reg<={8'h00, ir[7:0]}; addrm=2 → data_reg<=reg_rdata; addrm=3 → bus read at ir[ADDR_W-1:0] with data_reg<=mem_rdata; other addrm values → data_reg unchanged.
  - MEM_W: opcode==OP_STR → bus write of reg_rdata to ir[ADDR_W-1:0]; otherwise reg_we=1 for one cycle with reg_wdata=data_reg.
  - ALU_FETCH: alu_go=1 for one cycle.
  - ALU_OUT: reg_we=1, reg_wdata=alu_result.
  - JMP: conditions are JMP always, JZ z=1, JNZ z=0, JC c=1, JNC c=0. If the condition is true, pc<=ir[ADDR_W-1:0] and jmp_taken=1. Any non-jump opcode is not taken.
  - NEXT: no action (retires the instruction).
  - HALT: halt_req<=1.
  - Codes 9–15: treated as NEXT and set seq_err.
- Boundary conditions:
  - Overrun: state_valid while busy=1 is ignored and sets seq_err.
  - Halted: state_valid while halt_req=1 is ignored without an error.
  - Timeout: the counter starts at 0 on BUS entry and increments each cycle without ack. When it reaches TIMEOUT: mem_req drops, bus_err and halt_req are set, no register/PC/IR update occurs, and FSM goes to DONE.
  - mem_ack on the same cycle the counter reaches TIMEOUT counts as success.
  - mem_ack outside BUS is ignored.
- Sticky flags (halt_req, bus_err, seq_err) clear only on reset_cycle.

Optional Feature:
- Macro SEQ_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on every done pulse that completes a NEXT state (including illegal codes 9–15), wrapping 16'hFFFF→0.
- Undefined: instr_count is tied to 0 and no counter register is built.

Test Plan:
- pc=0x00, FETCH_INST, mem_rdata=16'h3812, ack after 3 cycles → ir=16'h3812, pc=0x01; done exactly 1 cycle after ack; mem_addr=0x00 stable throughout.
- MEM_R addrm=1, ir[7:0]=0x5A, then MEM_W with opcode≠OP_STR → reg_we pulse with reg_wdata=16'h005A; no mem_req.
- MEM_W opcode=OP_STR, reg_rdata=16'hBEEF, ir[7:0]=0x40 → mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=16'hBEEF until ack.
- JZ with z=0, then JZ with z=1 and ir[7:0]=0x20 → first leaves pc unchanged with no jmp_taken; second gives pc=0x20 and a jmp_taken pulse. Also pc=0xFF FETCH_INST → pc=0x00.
- FETCH_INST with ack never asserted, TIMEOUT=15 → mem_req drops after 15 cycles; bus_err=1, halt_req=1; ir unchanged; next state_valid ignored.
- state_valid during BUS → seq_err=1; reset_cycle mid-BUS → mem_req=0 at once, pc=RESET_PC, all flags 0. With SEQ_INSTR_COUNT_EN: 3 NEXT states → instr_count=3.

Source files
------------

// File: rtl/exec_bus_sequencer_if.sv
// exec_bus_sequencer_if
//   Memory bus between the execution sequencer (master) and memory (slave).
//   Signals:
//     mem_req    request, held until mem_ack or timeout
//     mem_we     1 = write, 0 = read
//     mem_addr   bus address (ADDR_W bits)
//     mem_wdata  write data
//     mem_rdata  read data, valid with mem_ack
//     mem_ack    one-cycle completion strobe from memory
interface exec_bus_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/exec_bus_sequencer.sv
// exec_bus_sequencer
//   Executes the per-cycle machine states issued by the CPU control unit:
//   PC/IR updates, memory bus transactions with timeout, register-write and
//   ALU-start strobes, and a sticky halt request back to the control unit.
//
//   Ports:
//     clk, reset_cycle          clock (rising edge), async active-high reset
//     state/state_valid         state code and its one-cycle strobe
//     opcode, addrm             current opcode and addressing mode
//     z_flag, c_flag            ALU flags (sampled when a JMP executes)
//     reg_rdata, alu_result     register-file source value, ALU output
//     bus                       memory bus (master modport)
//     pc, ir                    program counter, instruction register
//     reg_we, reg_wdata         register-file write strobe and data
//     alu_go, jmp_taken, done   one-cycle strobes
//     busy                      operation in progress (EXEC/BUS/DONE)
//     halt_req, bus_err, seq_err  sticky flags, cleared only by reset
//     instr_count               retired NEXT states
//
//   Optional feature: define SEQ_INSTR_COUNT_EN to build the retired
//   instruction counter; otherwise instr_count is tied to 0.
module exec_bus_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15,
    parameter logic [4:0]        OP_STR   = 5'h07,
    parameter logic [4:0]        OP_JMP   = 5'h0C,
    parameter logic [4:0]        OP_JZ    = 5'h0D,
    parameter logic [4:0]        OP_JNZ   = 5'h0E,
    parameter logic [4:0]        OP_JC    = 5'h0F,
    parameter logic [4:0]        OP_JNC   = 5'h10
) (
    input  logic                  clk,
    input  logic                  reset_cycle,
    input  logic [3:0]            state,
    input  logic                  state_valid,
    input  logic [4:0]            opcode,
    input  logic [2:0]            addrm,
    input  logic                  z_flag,
    input  logic                  c_flag,
    input  logic [15:0]           reg_rdata,
    input  logic [15:0]           alu_result,
    exec_bus_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]     pc,
    output logic [15:0]           ir,
    output logic                  reg_we,
    output logic [15:0]           reg_wdata,
    output logic                  alu_go,
    output logic                  jmp_taken,
    output logic                  busy,
    output logic                  done,
    output logic                  halt_req,
    output logic                  bus_err,
    output logic                  seq_err,
    output logic [15:0]           instr_count
);

    localparam logic [3:0] S_FETCH_PC   = 4'd0;
    localparam logic [3:0] S_FETCH_INST = 4'd1;
    localparam logic [3:0] S_MEM_R      = 4'd2;
    localparam logic [3:0] S_MEM_W      = 4'd3;
    localparam logic [3:0] S_ALU_FETCH  = 4'd4;
    localparam logic [3:0] S_ALU_OUT    = 4'd5;
    localparam logic [3:0] S_JMP        = 4'd6;
    localparam logic [3:0] S_NEXT       = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;

    // Timeout fires on the edge where the wait counter would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, BUS, DONE} fsm_t;

    fsm_t        fsm;
    logic [3:0]  cur_state;
    logic [4:0]  cur_op;
    logic [2:0]  cur_addrm;
    logic [15:0] data_reg;
    logic [7:0]  tcnt;

    logic              needs_bus;
    logic [ADDR_W-1:0] bus_addr;
    logic              jmp_cond;

    // Decode of the incoming state: which codes need a bus cycle and where.
    always_comb begin
        needs_bus = (state == S_FETCH_INST) ||
                    (state == S_MEM_R && addrm == 3'd3) ||
                    (state == S_MEM_W && opcode == OP_STR);
        bus_addr  = (state == S_FETCH_INST) ? pc : ir[ADDR_W-1:0];
    end

    // Flags are sampled live in EXEC; the opcode was latched on accept.
    always_comb begin
        jmp_cond = 1'b0;
        case (cur_op)
            OP_JMP:  jmp_cond = 1'b1;
            OP_JZ:   jmp_cond = z_flag;
            OP_JNZ:  jmp_cond = ~z_flag;
            OP_JC:   jmp_cond = c_flag;
            OP_JNC:  jmp_cond = ~c_flag;
            default: jmp_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            fsm           <= IDLE;
            cur_state     <= '0;
            cur_op        <= '0;
            cur_addrm     <= '0;
            data_reg      <= '0;
            tcnt          <= '0;
            pc            <= RESET_PC;
            ir            <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            reg_we        <= 1'b0;
            reg_wdata     <= '0;
            alu_go        <= 1'b0;
            jmp_taken     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            halt_req      <= 1'b0;
            bus_err       <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            reg_we    <= 1'b0;
            alu_go    <= 1'b0;
            jmp_taken <= 1'b0;

            // Overrun; once halted, new states are dropped silently instead.
            if (state_valid && !halt_req && fsm != IDLE)
                seq_err <= 1'b1;

            case (fsm)
                IDLE: begin
                    if (state_valid && !halt_req) begin
                        cur_state <= state;
                        cur_op    <= opcode;
                        cur_addrm <= addrm;
                        busy      <= 1'b1;
                        tcnt      <= '0;
                        if (needs_bus) begin
                            fsm           <= BUS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= (state == S_MEM_W);
                            bus.mem_addr  <= bus_addr;
                            bus.mem_wdata <= (state == S_MEM_W) ? reg_rdata : 16'h0000;
                        end else begin
                            fsm <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    fsm  <= DONE;
                    done <= 1'b1;
                    case (cur_state)
                        S_FETCH_PC:  bus.mem_addr <= pc;
                        S_MEM_R: begin
                            if (cur_addrm == 3'd1)      data_reg <= {8'h00, ir[7:0]};
                            else if (cur_addrm == 3'd2) data_reg <= reg_rdata;
                        end
                        S_MEM_W: begin
                            reg_we    <= 1'b1;
                            reg_wdata <= data_reg;
                        end
                        S_ALU_FETCH: alu_go <= 1'b1;
                        S_ALU_OUT: begin
                            reg_we    <= 1'b1;
                            reg_wdata <= alu_result;
                        end
                        S_JMP: begin
                            if (jmp_cond) begin
                                pc        <= ir[ADDR_W-1:0];
                                jmp_taken <= 1'b1;
                            end
                        end
                        S_NEXT:      ;
                        S_HALT:      halt_req <= 1'b1;
                        default:     seq_err <= 1'b1;  // codes 9..15 behave as NEXT
                    endcase
                end

                BUS: begin
                    // Ack wins even on the cycle the counter hits its limit.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        fsm         <= DONE;
                        done        <= 1'b1;
                        if (cur_state == S_FETCH_INST) begin
                            ir <= bus.mem_rdata;
                            pc <= pc + 1'b1;
                        end else if (cur_state == S_MEM_R) begin
                            data_reg <= bus.mem_rdata;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus_err     <= 1'b1;
                        halt_req    <= 1'b1;
                        tcnt        <= tcnt + 8'd1;
                        fsm         <= DONE;
                        done        <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                DONE: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end

                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] icnt;

    // Counts on the edge that raises done for a NEXT (or illegal) state.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle)
            icnt <= '0;
        else if (fsm == EXEC && (cur_state == S_NEXT || cur_state > S_HALT))
            icnt <= icnt + 16'd1;
    end

    assign instr_count = icnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_exec_bus_sequencer.sv
// tb_exec_bus_sequencer
//   Table of state vectors applied in order; each completion (done pulse) is
//   matched against an expected record queued when the state was issued.
//   Hand-written sequences cover timeout, halt, overrun, reset mid-bus and the
//   optional instruction counter.
module tb_exec_bus_sequencer;

    localparam logic [3:0] ST_FETCH_PC = 4'd0, ST_FETCH_INST = 4'd1, ST_MEM_R = 4'd2,
                           ST_MEM_W = 4'd3, ST_ALU_FETCH = 4'd4, ST_ALU_OUT = 4'd5,
                           ST_JMP = 4'd6, ST_NEXT = 4'd7;

    logic        clk = 1'b0;
    logic        reset_cycle = 1'b1;
    logic [3:0]  state = '0;
    logic        state_valid = 1'b0;
    logic [4:0]  opcode = '0;
    logic [2:0]  addrm = '0;
    logic        z_flag = 1'b0, c_flag = 1'b0;
    logic [15:0] reg_rdata = '0, alu_result = '0;
    logic [7:0]  pc;
    logic [15:0] ir, reg_wdata, instr_count;
    logic        reg_we, alu_go, jmp_taken, busy, done, halt_req, bus_err, seq_err;

    exec_bus_sequencer_if #(.ADDR_W(8)) bif ();

    exec_bus_sequencer dut (
        .clk(clk), .reset_cycle(reset_cycle), .state(state), .state_valid(state_valid),
        .opcode(opcode), .addrm(addrm), .z_flag(z_flag), .c_flag(c_flag),
        .reg_rdata(reg_rdata), .alu_result(alu_result), .bus(bif),
        .pc(pc), .ir(ir), .reg_we(reg_we), .reg_wdata(reg_wdata), .alu_go(alu_go),
        .jmp_taken(jmp_taken), .busy(busy), .done(done), .halt_req(halt_req),
        .bus_err(bus_err), .seq_err(seq_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;  logic [4:0] op; logic [2:0] am; logic z; logic c;
        logic [15:0] rr;  logic [15:0] ar; logic [15:0] md; int ack;
        logic [7:0]  e_addr; logic e_we; logic [15:0] e_wd;
        logic [7:0]  e_pc; logic [15:0] e_ir; logic e_rwe; logic [15:0] e_rwd;
        logic        e_jmp; logic e_alu;
    } vec_t;

    typedef struct {
        logic [7:0] pc; logic [15:0] ir; logic rwe; logic [15:0] rwd;
        logic jmp; logic alu; logic halt; logic berr;
    } exp_t;

    localparam int NV = 26;
    vec_t tbl [NV];
    exp_t sb_q [$];
    exp_t mon_e;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset_cycle && done) begin
            if (sb_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done_unexpected: got done=1 expected no completion pending");
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_pc", 32'(pc), 32'(mon_e.pc));
                chk("sb_ir", 32'(ir), 32'(mon_e.ir));
                chk("sb_reg_we", 32'(reg_we), 32'(mon_e.rwe));
                if (mon_e.rwe) chk("sb_reg_wdata", 32'(reg_wdata), 32'(mon_e.rwd));
                chk("sb_jmp_taken", 32'(jmp_taken), 32'(mon_e.jmp));
                chk("sb_alu_go", 32'(alu_go), 32'(mon_e.alu));
                chk("sb_halt_req", 32'(halt_req), 32'(mon_e.halt));
                chk("sb_bus_err", 32'(bus_err), 32'(mon_e.berr));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        state = v.st; opcode = v.op; addrm = v.am; z_flag = v.z; c_flag = v.c;
        reg_rdata = v.rr; alu_result = v.ar; state_valid = 1'b1;
        e = '{v.e_pc, v.e_ir, v.e_rwe, v.e_rwd, v.e_jmp, v.e_alu, 1'b0, 1'b0};
        sb_q.push_back(e);
        @(negedge clk);
        state_valid = 1'b0;
        if (v.ack >= 0) begin
            chk({name, "_req"}, 32'(bif.mem_req), 32'd1);
            repeat (v.ack) @(negedge clk);
            chk({name, "_req_held"}, 32'(bif.mem_req), 32'd1);
            chk({name, "_addr"}, 32'(bif.mem_addr), 32'(v.e_addr));
            chk({name, "_we"}, 32'(bif.mem_we), 32'(v.e_we));
            if (v.e_we) chk({name, "_wdata"}, 32'(bif.mem_wdata), 32'(v.e_wd));
            bif.mem_ack = 1'b1; bif.mem_rdata = v.md;
            @(negedge clk);
            bif.mem_ack = 1'b0; bif.mem_rdata = 16'h0;
            chk({name, "_done_after_ack"}, 32'(done), 32'd1);
        end else begin
            chk({name, "_no_req"}, 32'(bif.mem_req), 32'd0);
            chk({name, "_done_early"}, 32'(done), 32'd0);
            @(negedge clk);
            chk({name, "_done_lat"}, 32'(done), 32'd1);
        end
        wait_idle(name);
    endtask

    task automatic do_reset();
        reset_cycle = 1'b1;
        repeat (2) @(negedge clk);
        sb_q.delete();
        reset_cycle = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;
        exp_t e;
        bif.mem_ack = 1'b0; bif.mem_rdata = 16'h0;
        //            st             op     am    z     c     rr        ar        md       ack addr  we    wd        pc     ir        rwe   rwd       jmp   alu
        tbl[0]  = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3812,  3, 8'h00, 1'b0, 16'h0000, 8'h01, 16'h3812, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h105A,  0, 8'h01, 1'b0, 16'h0000, 8'h02, 16'h105A, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{ST_MEM_R,      5'h00, 3'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h02, 16'h105A, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{ST_MEM_W,      5'h01, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h02, 16'h105A, 1'b1, 16'h005A, 1'b0, 1'b0};
        tbl[4]  = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0740,  1, 8'h02, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{ST_MEM_W,      5'h07, 3'd0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'h0000,  2, 8'h40, 1'b1, 16'hBEEF, 8'h03, 16'h0740, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{ST_MEM_R,      5'h00, 3'd2, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{ST_MEM_W,      5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[8]  = '{ST_MEM_R,      5'h00, 3'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hABCD,  0, 8'h40, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{ST_MEM_W,      5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b1, 16'hABCD, 1'b0, 1'b0};
        tbl[10] = '{ST_ALU_FETCH,  5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[11] = '{ST_ALU_OUT,    5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h5555, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h03, 16'h0740, 1'b1, 16'h5555, 1'b0, 1'b0};
        tbl[12] = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0D20, 14, 8'h03, 1'b0, 16'h0000, 8'h04, 16'h0D20, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[13] = '{ST_JMP,        5'h0D, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h04, 16'h0D20, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[14] = '{ST_JMP,        5'h0D, 3'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[15] = '{ST_JMP,        5'h10, 3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[16] = '{ST_JMP,        5'h0F, 3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[17] = '{ST_JMP,        5'h0E, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[18] = '{ST_JMP,        5'h07, 3'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[19] = '{ST_MEM_R,      5'h00, 3'd5, 1'b0, 1'b0, 16'h7777, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[20] = '{ST_MEM_W,      5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h20, 16'h0D20, 1'b1, 16'hABCD, 1'b0, 1'b0};
        tbl[21] = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00FF,  0, 8'h20, 1'b0, 16'h0000, 8'h21, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[22] = '{ST_JMP,        5'h0C, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'hFF, 16'h00FF, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[23] = '{ST_FETCH_INST, 5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111,  2, 8'hFF, 1'b0, 16'h0000, 8'h00, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[24] = '{ST_FETCH_PC,   5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h00, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[25] = '{ST_NEXT,       5'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, -1, 8'h00, 1'b0, 16'h0000, 8'h00, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_req", 32'(bif.mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({halt_req, bus_err, seq_err, done, reg_we, alu_go, jmp_taken}), 32'd0);
        chk("rst_icnt", 32'(instr_count), 32'd0);
        reset_cycle = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        chk("fetch_pc_addr", 32'(bif.mem_addr), 32'h00);
        chk("no_seq_err", 32'(seq_err), 32'd0);

        // Timeout: no ack ever; pc=0, ir=16'h1111 must survive
        @(negedge clk);
        state = ST_FETCH_INST; state_valid = 1'b1;
        e = '{8'h00, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        sb_q.push_back(e);
        @(negedge clk);
        state_valid = 1'b0;
        n = 0;
        while (bif.mem_req && n < 40) begin n++; @(negedge clk); end
        chk("tmo_req_cycles", 32'(n), 32'd15);
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        chk("tmo_halt", 32'(halt_req), 32'd1);
        chk("tmo_ir", 32'(ir), 32'h1111);
        wait_idle("tmo");
        // Halted: new state ignored silently; stray ack ignored
        state = ST_NEXT; state_valid = 1'b1;
        @(negedge clk);
        state_valid = 1'b0;
        bif.mem_ack = 1'b1; bif.mem_rdata = 16'h9999;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_no_seq_err", 32'(seq_err), 32'd0);
        chk("halt_pc_ir", 32'({pc, ir}), 32'h00_1111);

        // Instruction counter after fresh reset
        do_reset();
        chk("rst2_flags", 32'({halt_req, bus_err, seq_err}), 32'd0);
        v = tbl[25]; v.e_pc = 8'h00; v.e_ir = 16'h0000;
        for (int i = 0; i < 3; i++) run_vec(v, $sformatf("next%0d", i));
`ifdef SEQ_INSTR_COUNT_EN
        chk("icnt_3", 32'(instr_count), 32'd3);
`else
        chk("icnt_tied", 32'(instr_count), 32'd0);
`endif
        // Illegal code behaves as NEXT and flags seq_err
        v.st = 4'd11;
        run_vec(v, "illegal");
        chk("illegal_seq_err", 32'(seq_err), 32'd1);
`ifdef SEQ_INSTR_COUNT_EN
        chk("icnt_4", 32'(instr_count), 32'd4);
`endif

        // Overrun during BUS, then reset mid-BUS
        do_reset();
        @(negedge clk);
        state = ST_FETCH_INST; state_valid = 1'b1;
        @(negedge clk);
        chk("ovr_req", 32'(bif.mem_req), 32'd1);
        state = ST_NEXT;                       // still asserted: overrun
        @(negedge clk);
        state_valid = 1'b0;
        chk("ovr_seq_err", 32'(seq_err), 32'd1);
        chk("ovr_busy", 32'(busy), 32'd1);
        reset_cycle = 1'b1;
        #1;
        chk("rstbus_req", 32'(bif.mem_req), 32'd0);
        chk("rstbus_pc", 32'(pc), 32'h00);
        chk("rstbus_flags", 32'({halt_req, bus_err, seq_err, busy}), 32'd0);
        @(negedge clk);
        sb_q.delete();
        reset_cycle = 1'b0;
        bif.mem_ack = 1'b1; bif.mem_rdata = 16'h4242;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_ack_ir", 32'(ir), 32'h0);
        chk("late_ack_pc", 32'(pc), 32'h0);
        chk("late_ack_busy", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
